// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter: ALU op codes, default
// datapath width, the CMP status flag bundle and result buffer states.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_SUBI = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_MOVI = 4'hA;
    localparam logic [3:0] OP_SLL  = 4'hB;
    localparam logic [3:0] OP_SLR  = 4'hC;
    localparam logic [3:0] OP_SLLV = 4'hD;
    localparam logic [3:0] OP_SLRV = 4'hE;
    localparam logic [3:0] OP_ZERO = 4'hF;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: op/a/b -> result, plus the raw subtract flags
// (the caller decides when they become architectural).
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              v
);

    logic [DATA_W-1:0] w_diff;

    assign w_diff = a - b;

    // Result select; shift amount uses only the low five bits of B.
    always_comb begin
        result = '0;
        case (op)
            OP_AND, OP_ANDI:                result = a & b;
            OP_ADD, OP_ADDI, OP_LD, OP_ST:  result = a + b;
            OP_SUB, OP_CMP, OP_SUBI:        result = w_diff;
            OP_MOV, OP_MOVI:                result = a;
            OP_SLL, OP_SLLV:                result = a << b[4:0];
            OP_SLR, OP_SLRV:                result = a >> b[4:0];
            default:                        result = '0;
        endcase
    end

    assign z = (w_diff == '0);
    assign c = (a < b);
    assign v = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// one-entry registered result buffer and the architectural CMP flags.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
//
// Result buffer states:
//   state     | meaning
//   BUF_EMPTY | no result held, res_valid=0
//   BUF_FULL  | result held until res_ready, res_valid=1
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
    output logic [TAG_W-1:0]  res_tag,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       stall_cnt,
`endif
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v
);

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic              r_rr;
    logic [DATA_W-1:0] r_data;
    logic              r_src;
    logic [TAG_W-1:0]  r_tag;
    flags_t            r_flags;

    logic              w_can_accept;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt_any;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_z;
    logic              w_alu_c;
    logic              w_alu_v;

    // Nothing is granted while reset is held, so requests pending across
    // reset are re-arbitrated from a clean pointer afterwards.
    assign w_can_accept = !reset && ((r_state == BUF_EMPTY) || res_ready);
    assign w_gnt0       = w_can_accept && req0_valid && (!req1_valid || !r_rr);
    assign w_gnt1       = w_can_accept && req1_valid && (!req0_valid ||  r_rr);
    assign w_gnt_any    = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_op  = w_gnt1 ? req1_op  : req0_op;
    assign w_a   = w_gnt1 ? req1_a   : req0_a;
    assign w_b   = w_gnt1 ? req1_b   : req0_b;
    assign w_tag = w_gnt1 ? req1_tag : req0_tag;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .op     (w_op),
        .a      (w_a),
        .b      (w_b),
        .result (w_alu_res),
        .z      (w_alu_z),
        .c      (w_alu_c),
        .v      (w_alu_v)
    );

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= BUF_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Buffer next state: a grant always fills, a take without a grant empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUF_EMPTY: if (w_gnt_any) w_state_nxt = BUF_FULL;
            BUF_FULL:  if (!w_gnt_any && res_ready) w_state_nxt = BUF_EMPTY;
            default:   w_state_nxt = BUF_EMPTY;
        endcase
    end

    // Result payload, round-robin pointer and CMP flags, all loaded on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_src   <= 1'b0;
            r_tag   <= '0;
            r_rr    <= 1'b0;
            r_flags <= '0;
        end else if (w_gnt_any) begin
            r_data <= w_alu_res;
            r_src  <= w_gnt1;
            r_tag  <= w_tag;
            r_rr   <= w_gnt0;
            if (w_op == OP_CMP) r_flags <= '{z: w_alu_z, c: w_alu_c, v: w_alu_v};
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_stall_cnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_gnt0) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            if (w_gnt1) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            if ((req0_valid || req1_valid) && !w_gnt_any) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`endif

    assign res_valid = (r_state == BUF_FULL);
    assign res_data  = r_data;
    assign res_src   = r_src;
    assign res_tag   = r_tag;
    assign flag_z    = r_flags.z;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;

endmodule
